// File: rtl/prog_loader.sv
// Boot loader: turns a length-prefixed, XOR-checksummed byte stream into 32-bit writes on the core's memory port.
// Each word is written one cycle after its 4th byte arrives, and rx_ready drops for that write cycle.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        ext_mem_write,
    output logic [31:0] ext_write_data,
    output logic [31:0] ext_data_adr,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        CNT0 = 3'd0,
        CNT1 = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        RUN  = 3'd4,
        FAIL = 3'd5
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q;
    logic [15:0] count_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] asm_q;
    logic [7:0]  csum_q;
    logic        wr_q;
    logic [31:0] wdata_q;
    logic [31:0] adr_q;
    logic        core_reset_q;
    logic        done_q;
    logic        error_q;

    logic        accept;
    logic [15:0] count_d;
    logic [15:0] word_idx_d;

    // Accepting states are still blocked during the write cycle that follows a completed word.
    assign rx_ready   = !reset && !wr_q &&
                        (state_q == CNT0 || state_q == CNT1 || state_q == DATA || state_q == CSUM);
    assign accept     = rx_valid && rx_ready;
    assign count_d    = {rx_data, count_q[7:0]};
    assign word_idx_d = word_idx_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CNT0;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            csum_q       <= '0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            adr_q        <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                CNT0: begin
                    csum_q <= '0;
                    if (accept) begin
                        count_q[7:0] <= rx_data;
                        state_q      <= CNT1;
                    end
                end
                CNT1: begin
                    if (accept) begin
                        count_q[15:8] <= rx_data;
                        if ({1'b0, count_d} > MAX_W) begin
                            state_q <= FAIL;
                            error_q <= 1'b1;
                        end else if (count_d == 16'd0) begin
                            state_q <= CSUM;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum_q     <= csum_q ^ rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: asm_q[7:0]   <= rx_data;
                            2'd1: asm_q[15:8]  <= rx_data;
                            2'd2: asm_q[23:16] <= rx_data;
                            default: begin
                                wr_q       <= 1'b1;
                                wdata_q    <= {rx_data, asm_q};
                                adr_q      <= BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                                word_idx_q <= word_idx_d;
                                if (word_idx_d == count_q) begin
                                    state_q <= CSUM;
                                end
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (rx_data == csum_q) begin
                            state_q      <= RUN;
                            core_reset_q <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            state_q <= FAIL;
                            error_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    core_reset_q <= 1'b0;
                    done_q       <= 1'b1;
                end
                default: begin
                    state_q      <= FAIL;
                    core_reset_q <= 1'b1;
                    error_q      <= 1'b1;
                end
            endcase
        end
    end

    assign ext_mem_write  = wr_q;
    assign ext_write_data = wdata_q;
    assign ext_data_adr   = adr_q;
    assign core_reset     = core_reset_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: BASE_ADDR, default 32'h0, byte address of the first program word written.
REQ-002 Parameter: MAX_WORDS, default 64, largest accepted word count.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  byte-stream source has a byte on rx_data.
REQ-006 rx_data  input  8  program byte.
REQ-007 rx_ready  output  1  loader accepts rx_data this cycle; a transfer occurs when rx_valid && rx_ready.
REQ-008 ext_mem_write  output  1  one-cycle write strobe to the core's external memory write port.
REQ-009 ext_write_data  output  32  word to write.
REQ-010 ext_data_adr  output  32  byte address of the word.
REQ-011 core_reset  output  1  holds the core in reset while high.
REQ-012 done  output  1  load completed and checksum matched; core released.
REQ-013 error  output  1  load aborted; core held in reset.

Function
REQ-014 The stream format SHALL be: count_lo, count_hi (16-bit word count, little-endian), then count words of 4 bytes each (little-endian), then 1 checksum byte.
REQ-015 The FSM states SHALL be CNT0 -> CNT1 -> DATA -> CSUM -> RUN, plus FAIL.
REQ-016 CNT0: accept a byte into count[7:0], then go to CNT1.
REQ-017 CNT1: accept a byte into count[15:8]. If count > MAX_WORDS, go to FAIL. If count == 0, go to CSUM. Otherwise go to DATA.
REQ-018 DATA: a 2-bit byte index places each accepted byte at bits [8*idx+7 : 8*idx] of an assembly register.
REQ-019 On acceptance of the 4th byte of a word, the next cycle SHALL drive ext_mem_write=1 for exactly one cycle, with ext_write_data = the assembled word and ext_data_adr = BASE_ADDR + 4*word_index.
REQ-020 rx_ready SHALL be 0 in every cycle where ext_mem_write=1, so no byte is accepted during a write.
REQ-021 word_index SHALL increment after each write. After the write of word count-1, the FSM goes to CSUM.
REQ-022 Running checksum = XOR of all data bytes only; the count bytes are excluded. It SHALL be cleared in CNT0.
REQ-023 CSUM: accept one byte. If it equals the running checksum, go to RUN; otherwise go to FAIL.
REQ-024 rx_ready SHALL be 1 in CNT0, CNT1, DATA (except write cycles) and CSUM. It SHALL be 0 in RUN and FAIL.
REQ-025 Cycles with rx_valid=0 SHALL not advance any state, index or checksum. Gaps of any length are legal.
REQ-026 RUN: core_reset=0, done=1. RUN SHALL be held until reset. Later rx bytes SHALL be ignored (not accepted).
REQ-027 FAIL: core_reset=1, error=1, ext_mem_write=0. FAIL SHALL be held until reset.
REQ-028 core_reset SHALL be 1 in every state except RUN, and SHALL go to 0 in the first cycle after the accepted checksum byte.
REQ-029 ext_mem_write SHALL be 0 outside DATA write cycles. ext_write_data and ext_data_adr are don't-care when ext_mem_write=0, but SHALL be deterministic (hold last value).
REQ-030 Address arithmetic SHALL be 32-bit with wrap-around modulo 2^32; there is no overflow flag.

Reset
REQ-031 While reset=1 at a rising edge, the following SHALL hold:
- state=CNT0; count, byte index, word_index and checksum = 0.
- ext_mem_write=0, ext_write_data=0, ext_data_adr=0.
- core_reset=1, done=0, error=0.
- rx_ready=0 during the reset cycle.
REQ-032 Reset asserted mid-load (any state) SHALL abandon the partial word without a write, and SHALL restart at CNT0 on the first cycle after reset deasserts.

Verification
REQ-033 Stream 02 00 | 13 01 50 00 | 13 00 00 00 | 51 with BASE_ADDR=0, continuous valid:
- exactly two ext_mem_write pulses: 0x00500113@0x0, then 0x00000013@0x4;
- then done=1, core_reset=0, error=0.
REQ-034 Same stream with checksum byte 52: two writes occur, then error=1, core_reset=1, done=0, rx_ready=0.
REQ-035 Count bytes 41 00 (65 > MAX_WORDS=64): FAIL after the second byte, with no ext_mem_write pulses.
REQ-036 Stream 00 00 00 (count 0, checksum 0): no writes, then done=1 after the third accepted byte.
REQ-037 The REQ-033 stream with rx_valid toggling 1/0 every cycle: the same two writes with the same data and addresses, then done=1.
REQ-038 Reset asserted after 2 data bytes, then the full REQ-033 stream: no write during the aborted load; the full load then completes as in REQ-033.
